// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter feeding one UART transmitter through a single output register.
// Ownership is held for a whole packet; an idle lock is broken after LOCK_TIMEOUT empty cycles.
module uart_tx_arbiter #(
  parameter int DW           = 8,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  input  logic [2*DW-1:0] req_data,
  input  logic [1:0]      req_last,
  output logic [1:0]      req_ready,
  output logic            tx_valid,
  output logic [DW-1:0]   tx_data,
  input  logic            tx_ready,
  output logic [1:0]      grant,
  output logic            timeout_pulse
);

  localparam logic [1:0]  IDLE       = 2'd0;
  localparam logic [1:0]  GRANT0     = 2'd1;
  localparam logic [1:0]  GRANT1     = 2'd2;
  // Release fires on the cycle that would bring the idle count up to LOCK_TIMEOUT.
  localparam logic [15:0] IDLE_LIMIT = 16'(LOCK_TIMEOUT - 1);

  logic [1:0]    state_reg, state_next;
  logic          ptr_reg, ptr_next;
  logic [15:0]   idle_cnt_reg, idle_cnt_next;
  logic          timeout_reg, timeout_next;
  logic          tx_valid_reg;
  logic [DW-1:0] tx_data_reg;

  logic          granted;
  logic          owner;
  logic          out_free;
  logic          owner_valid;
  logic          owner_last;
  logic          owner_accept;
  logic          idle_hit;
  logic [DW-1:0] owner_data;

  assign granted      = (state_reg == GRANT0) || (state_reg == GRANT1);
  assign owner        = (state_reg == GRANT1);
  assign out_free     = !tx_valid_reg || tx_ready;
  assign owner_valid  = granted && req_valid[owner];
  assign owner_last   = req_last[owner];
  assign owner_accept = owner_valid && out_free;
  assign owner_data   = owner ? req_data[2*DW-1:DW] : req_data[DW-1:0];
  assign idle_hit     = granted && !owner_valid && (idle_cnt_reg == IDLE_LIMIT);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = granted && (owner == 1'(gi)) && out_free;
      assign grant[gi]     = (state_reg == ((gi == 0) ? GRANT0 : GRANT1));
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idle_cnt_next = idle_cnt_reg;
    timeout_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        idle_cnt_next = '0;
        if (req_valid == 2'b01)      state_next = GRANT0;
        else if (req_valid == 2'b10) state_next = GRANT1;
        else if (req_valid == 2'b11) state_next = ptr_reg ? GRANT1 : GRANT0;
      end
      GRANT0, GRANT1: begin
        if (owner_accept) begin
          idle_cnt_next = '0;
          if (owner_last) begin
            state_next = IDLE;
            ptr_next   = !owner;
          end
        end else if (!owner_valid) begin
          if (idle_hit) begin
            state_next    = IDLE;
            ptr_next      = !owner;
            timeout_next  = 1'b1;
            idle_cnt_next = '0;
          end else begin
            idle_cnt_next = idle_cnt_reg + 16'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= 1'b0;
      idle_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      idle_cnt_reg <= idle_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  // A pending byte survives a release; only a new accept or a drain changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else if (owner_accept) begin
      tx_valid_reg <= 1'b1;
      tx_data_reg  <= owner_data;
    end else if (tx_ready) begin
      tx_valid_reg <= 1'b0;
    end
  end

  assign tx_valid      = tx_valid_reg;
  assign tx_data       = tx_data_reg;
  assign timeout_pulse = timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed packets, a per-cycle rule model, a byte scoreboard
// and literal expectations for order, latency, backpressure, timeout and reset.
module tb_uart_tx_arbiter;

  localparam int LT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  grant;
  logic        timeout_pulse;

  logic       rv [2];
  logic [7:0] rd [2];
  logic       rl [2];
  logic       abort;

  assign req_valid = {rv[1], rv[0]};
  assign req_data  = {rd[1], rd[0]};
  assign req_last  = {rl[1], rl[0]};

  uart_tx_arbiter #(.DW(8), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Observed output stream (bytes and the cycle each was taken by the transmitter).
  logic [7:0] out_q [$];
  int         out_cyc [$];
  logic [7:0] sb [$];

  // Rule model: owner (0 none, 1 req0, 2 req1), round-robin preference, idle run length.
  int         m_owner, m_idle;
  logic       m_fav1, m_pulse;
  logic [1:0] p_valid, p_ready, p_last, acc, e_ready;
  logic [7:0] p_rd [2];
  logic       p_txv, p_txr, e_txv, out_ok;
  logic [7:0] p_txd, e_txd;
  int         own;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_grant", grant, 2'b00);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_timeout", timeout_pulse, 1'b0);
      m_owner = 0; m_idle = 0; m_fav1 = 1'b0; m_pulse = 1'b0;
      sb.delete();
      p_valid = '0; p_ready = '0; p_last = '0; p_txv = 1'b0; p_txr = 1'b0;
      p_txd = '0; p_rd[0] = '0; p_rd[1] = '0;
    end else begin
      acc = p_valid & p_ready;
      // Output register expectation from the previous cycle's handshakes.
      e_txd = p_txd;
      if (acc[0])                begin e_txv = 1'b1; e_txd = p_rd[0]; end
      else if (acc[1])           begin e_txv = 1'b1; e_txd = p_rd[1]; end
      else if (p_txv && !p_txr)  e_txv = 1'b1;
      else                       e_txv = 1'b0;
      chk("tx_valid", tx_valid, e_txv);
      if (e_txv) chk("tx_data", tx_data, e_txd);

      // Ownership rules.
      m_pulse = 1'b0;
      if (m_owner == 0) begin
        m_idle = 0;
        if (p_valid == 2'b11)      m_owner = m_fav1 ? 2 : 1;
        else if (p_valid == 2'b01) m_owner = 1;
        else if (p_valid == 2'b10) m_owner = 2;
      end else begin
        own = m_owner - 1;
        if (acc[own]) begin
          m_idle = 0;
          if (p_last[own]) begin m_owner = 0; m_fav1 = (own == 0); end
        end else if (!p_valid[own]) begin
          m_idle++;
          if (m_idle == LT) begin
            m_owner = 0; m_fav1 = (own == 0); m_pulse = 1'b1; m_idle = 0;
          end
        end
      end
      chk("grant", grant, (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00);
      chk("timeout_pulse", timeout_pulse, m_pulse);
      out_ok  = !tx_valid || tx_ready;
      e_ready = (m_owner == 1) ? {1'b0, out_ok} : (m_owner == 2) ? {out_ok, 1'b0} : 2'b00;
      chk("req_ready", req_ready, e_ready);

      // Scoreboard: every accepted byte leaves exactly once, in order.
      if (tx_valid && tx_ready) begin
        out_q.push_back(tx_data);
        out_cyc.push_back(cyc);
        if (sb.size() == 0) chk("sb_unexpected_byte", tx_data, 32'hFFFF_FFFF);
        else                chk("sb_byte", tx_data, sb.pop_front());
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i]) sb.push_back(rd[i]);

      p_valid = req_valid; p_ready = req_ready; p_last = req_last;
      p_rd[0] = rd[0]; p_rd[1] = rd[1];
      p_txv = tx_valid; p_txr = tx_ready; p_txd = tx_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the final byte is taken.
  task automatic send_pkt(input int r, input logic [7:0] pk [$], input bit with_last);
    int n;
    for (int k = 0; k < pk.size(); k++) begin
      rv[r] = 1'b1;
      rd[r] = pk[k];
      rl[r] = with_last && (k == pk.size() - 1);
      n = 0;
      @(negedge clk);
      while (!req_ready[r] && !abort && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (abort) break;
      if (n >= 200) begin
        chk("send_bound", n, 0);
        break;
      end
      @(posedge clk); #1;
    end
    rv[r] = 1'b0;
    rl[r] = 1'b0;
  endtask

  task automatic check_stream(input string nm, input logic [7:0] e [$]);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, "_len"}, out_q.size(), e.size());
    for (int i = 0; i < e.size() && i < out_q.size(); i++)
      chk({nm, "_byte"}, out_q[i], e[i]);
  endtask

  task automatic clear_stream();
    out_q.delete();
    out_cyc.delete();
  endtask

  logic [7:0] pa [$];
  logic [7:0] pb [$];
  logic [7:0] ex [$];
  int         w;

  initial begin
    rst_n = 1'b0; tx_ready = 1'b1; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin rv[i] = 1'b0; rd[i] = '0; rl[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention right after reset: requester 0 first.
    pa = {8'hA0, 8'hA1}; pb = {8'hB0, 8'hB1};
    fork
      send_pkt(0, pa, 1'b1);
      send_pkt(1, pb, 1'b1);
    join
    ex = {8'hA0, 8'hA1, 8'hB0, 8'hB1};
    check_stream("contend_rr0", ex);
    clear_stream();

    // Single packet, grant one cycle after valid, back-to-back bytes.
    pa = {8'h41, 8'h42, 8'h43};
    fork
      send_pkt(0, pa, 1'b1);
      begin
        @(negedge clk); chk("single_grant_idle", grant, 2'b00);
        @(negedge clk); chk("single_grant_first", grant, 2'b01);
      end
    join
    ex = {8'h41, 8'h42, 8'h43};
    check_stream("single", ex);
    if (out_cyc.size() == 3) chk("single_b2b", out_cyc[2] - out_cyc[0], 2);
    else                     chk("single_b2b_count", out_cyc.size(), 3);
    clear_stream();

    // Requester 0 was served last, so requester 1 wins this contention.
    pa = {8'hC0}; pb = {8'hD0};
    fork
      send_pkt(0, pa, 1'b1);
      send_pkt(1, pb, 1'b1);
    join
    ex = {8'hD0, 8'hC0};
    check_stream("contend_rr1", ex);
    clear_stream();

    // Backpressure: 0x55 held for 10 cycles, nothing lost.
    tx_ready = 1'b0;
    pa = {8'h55, 8'h56, 8'h57};
    fork
      send_pkt(0, pa, 1'b1);
      begin
        w = 0;
        @(negedge clk);
        while (!tx_valid && w < 50) begin w++; @(negedge clk); end
        if (w >= 50) chk("bp_wait_tx_valid", w, 0);
        for (int k = 0; k < 10; k++) begin
          chk("bp_hold_data", tx_data, 8'h55);
          chk("bp_hold_valid", tx_valid, 1'b1);
          chk("bp_ready_low", req_ready, 2'b00);
          @(negedge clk);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
      end
    join
    ex = {8'h55, 8'h56, 8'h57};
    check_stream("backpressure", ex);
    clear_stream();

    // Lock timeout: requester 1 stalls mid-packet; a stray last without valid is ignored.
    pb = {8'h10};
    send_pkt(1, pb, 1'b0);
    rl[1] = 1'b1;
    pa = {8'h20};
    fork
      send_pkt(0, pa, 1'b1);
      begin
        for (int k = 0; k < LT; k++) begin
          @(negedge clk);
          chk("to_grant_held", grant, 2'b10);
          chk("to_no_pulse", timeout_pulse, 1'b0);
        end
        @(negedge clk);
        chk("to_pulse", timeout_pulse, 1'b1);
        chk("to_grant_idle", grant, 2'b00);
        @(negedge clk);
        chk("to_pulse_end", timeout_pulse, 1'b0);
        chk("to_next_grant", grant, 2'b01);
      end
    join
    rl[1] = 1'b0;
    ex = {8'h10, 8'h20};
    check_stream("timeout", ex);
    clear_stream();

    // Reset mid-packet with a byte stuck in the output register.
    tx_ready = 1'b0;
    pa = {8'h60, 8'h61, 8'h62};
    fork
      send_pkt(0, pa, 1'b1);
      begin
        w = 0;
        @(negedge clk);
        while (!tx_valid && w < 50) begin w++; @(negedge clk); end
        if (w >= 50) chk("rst_wait_tx_valid", w, 0);
        #2 abort = 1'b1; rst_n = 1'b0;
        #1;
        chk("async_rst_tx_valid", tx_valid, 1'b0);
        chk("async_rst_ready", req_ready, 2'b00);
        chk("async_rst_grant", grant, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    abort = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    pa = {8'h70}; pb = {8'h80};
    fork
      send_pkt(0, pa, 1'b1);
      send_pkt(1, pb, 1'b1);
    join
    ex = {8'h70, 8'h80};
    check_stream("after_reset", ex);
    clear_stream();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
